// File: rtl/perceptron_trainer.sv
// Perceptron branch-predictor training stage: applies the saturating +/-1 training
// rule to one weight row, LANES weights per cycle, and writes the row back.
module perceptron_trainer #(
   parameter int NUM_PERCEPTRONS = 128,
   parameter int HISTORY_LENGTH  = 32,
   parameter int WEIGHT_WIDTH    = 8,
   parameter int ADDR_WIDTH      = $clog2(NUM_PERCEPTRONS),
   parameter int SUM_WIDTH       = WEIGHT_WIDTH + $clog2(HISTORY_LENGTH + 1) + 1,
   parameter int THETA           = 75,
   parameter int LANES           = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           upd_valid,
   output logic                           upd_ready,
   input  logic [ADDR_WIDTH-1:0]          upd_addr,
   input  logic [HISTORY_LENGTH-1:0]      upd_history,
   input  logic                           upd_taken,
   input  logic signed [SUM_WIDTH-1:0]    upd_sum,
   output logic [ADDR_WIDTH-1:0]          tbl_read_addr,
   input  logic signed [WEIGHT_WIDTH-1:0] tbl_weights [HISTORY_LENGTH:0],
   output logic                           tbl_write_en,
   output logic [ADDR_WIDTH-1:0]          tbl_write_addr,
   output logic signed [WEIGHT_WIDTH-1:0] tbl_new_weights [HISTORY_LENGTH:0],
   output logic [15:0]                    trained_cnt,
   output logic [15:0]                    skipped_cnt
);

   localparam int NUM_WEIGHTS = HISTORY_LENGTH + 1;
   localparam int PASSES      = (NUM_WEIGHTS + LANES - 1) / LANES;
   localparam int PASS_W      = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

   localparam logic signed [SUM_WIDTH-1:0] THETA_POS = SUM_WIDTH'(THETA);
   localparam logic signed [SUM_WIDTH-1:0] THETA_NEG = -THETA_POS;

   localparam logic signed [WEIGHT_WIDTH:0] W_MAX   = (WEIGHT_WIDTH+1)'((1 << (WEIGHT_WIDTH - 1)) - 1);
   localparam logic signed [WEIGHT_WIDTH:0] W_MIN   = (WEIGHT_WIDTH+1)'(-(1 << (WEIGHT_WIDTH - 1)));
   localparam logic signed [WEIGHT_WIDTH:0] STEP_UP = (WEIGHT_WIDTH+1)'(1);
   localparam logic signed [WEIGHT_WIDTH:0] STEP_DN = (WEIGHT_WIDTH+1)'(-1);

   typedef enum logic [1:0] {IDLE, FETCH, UPDATE, WRITE} state_t;

   state_t                         state, state_nxt;
   logic [ADDR_WIDTH-1:0]          cap_addr;
   logic [HISTORY_LENGTH-1:0]      cap_hist;
   logic                           cap_taken;
   logic [PASS_W-1:0]              pass;
   logic signed [WEIGHT_WIDTH-1:0] row_q   [HISTORY_LENGTH:0];
   logic signed [WEIGHT_WIDTH-1:0] row_nxt [HISTORY_LENGTH:0];
   logic [NUM_WEIGHTS-1:0]         x_pos;
   logic signed [WEIGHT_WIDTH:0]   wide;
   logic                           inc;
   logic                           train;

   // Signed compares against +/-THETA instead of abs(), so the most negative sum is safe.
   assign train = ((upd_sum >= 0) != upd_taken) ||
                  ((upd_sum <= THETA_POS) && (upd_sum >= THETA_NEG));

   // Bit j is 1 when input x_j is +1; the bias input x_0 is always +1.
   assign x_pos         = {cap_hist, 1'b1};
   assign tbl_read_addr = cap_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (upd_valid && train) state_nxt = FETCH;
         FETCH:   state_nxt = UPDATE;
         UPDATE:  if (pass == LAST_PASS) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      upd_ready    = (state == IDLE);
      tbl_write_en = (state == WRITE);
   end

   // Only weights belonging to the current pass change; lanes past HISTORY_LENGTH do not exist.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      row_nxt = row_q;
      wide    = '0;
      inc     = 1'b0;
      for (int j = 0; j < NUM_WEIGHTS; j++) begin
         if (j / LANES == int'(pass)) begin
            inc  = (cap_taken == x_pos[j]);
            wide = {row_q[j][WEIGHT_WIDTH-1], row_q[j]};
            wide = wide + (inc ? STEP_UP : STEP_DN);
            if (wide > W_MAX)      row_nxt[j] = W_MAX[WEIGHT_WIDTH-1:0];
            else if (wide < W_MIN) row_nxt[j] = W_MIN[WEIGHT_WIDTH-1:0];
            else                   row_nxt[j] = wide[WEIGHT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_addr       <= '0;
         cap_hist       <= '0;
         cap_taken      <= 1'b0;
         pass           <= '0;
         tbl_write_addr <= '0;
         trained_cnt    <= '0;
         skipped_cnt    <= '0;
         // NOTE: the row registers are flops, not RAM, so clearing them on reset is cheap and deterministic.
         for (int j = 0; j < NUM_WEIGHTS; j++) begin
            row_q[j]           <= '0;
            tbl_new_weights[j] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (upd_valid) begin
                  cap_addr  <= upd_addr;
                  cap_hist  <= upd_history;
                  cap_taken <= upd_taken;
                  if (!train && skipped_cnt != 16'hFFFF) skipped_cnt <= skipped_cnt + 16'd1;
               end
            end
            FETCH: begin
               row_q <= tbl_weights;
               pass  <= '0;
            end
            UPDATE: begin
               row_q <= row_nxt;
               pass  <= pass + PASS_W'(1);
               // Write-port registers load only here, so they hold between writes.
               if (pass == LAST_PASS) begin
                  tbl_new_weights <= row_nxt;
                  tbl_write_addr  <= cap_addr;
               end
            end
            WRITE: begin
               if (trained_cnt != 16'hFFFF) trained_cnt <= trained_cnt + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: stimulus pushes expected row writes into a
// scoreboard queue; a monitor process pops and compares on every table write strobe.
module tb_perceptron_trainer;

   localparam int NP = 128;
   localparam int HL = 32;
   localparam int WW = 8;
   localparam int AW = 7;
   localparam int SW = WW + $clog2(HL + 1) + 1;
   localparam int RW = (HL + 1) * WW;

   typedef logic [HL:0][WW-1:0] row_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      row_t          row;
      logic [31:0]   cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 upd_valid;
   logic                 upd_ready;
   logic [AW-1:0]        upd_addr;
   logic [HL-1:0]        upd_history;
   logic                 upd_taken;
   logic signed [SW-1:0] upd_sum;
   logic [AW-1:0]        tbl_read_addr;
   logic signed [WW-1:0] tbl_weights [HL:0];
   logic                 tbl_write_en;
   logic [AW-1:0]        tbl_write_addr;
   logic signed [WW-1:0] tbl_new_weights [HL:0];
   logic [15:0]          trained_cnt;
   logic [15:0]          skipped_cnt;

   row_t           mem [NP];
   logic           load_en;
   logic [AW-1:0]  load_addr;
   logic [WW-1:0]  load_val;
   int             cyc = 0;
   int             checks = 0;
   int             errors = 0;
   exp_t           sb [$];

   perceptron_trainer dut (
      .clk(clk), .rst(rst),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
      .upd_history(upd_history), .upd_taken(upd_taken), .upd_sum(upd_sum),
      .tbl_read_addr(tbl_read_addr), .tbl_weights(tbl_weights),
      .tbl_write_en(tbl_write_en), .tbl_write_addr(tbl_write_addr),
      .tbl_new_weights(tbl_new_weights),
      .trained_cnt(trained_cnt), .skipped_cnt(skipped_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Weight table model: combinational read, write on the strobe, plus a preload port.
   always_comb begin
      for (int i = 0; i <= HL; i++) tbl_weights[i] = mem[tbl_read_addr][i];
   end

   always @(posedge clk) begin
      if (tbl_write_en)
         for (int i = 0; i <= HL; i++) mem[tbl_write_addr][i] <= tbl_new_weights[i];
      if (load_en)
         for (int i = 0; i <= HL; i++) mem[load_addr][i] <= load_val;
   end

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic row_t fill(input logic [WW-1:0] v);
      row_t r;
      for (int i = 0; i <= HL; i++) r[i] = v;
      return r;
   endfunction

   task automatic monitor();
      exp_t e;
      row_t got;
      forever begin
         @(negedge clk);
         if (tbl_write_en === 1'b1) begin
            if (sb.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               e = sb.pop_front();
               for (int i = 0; i <= HL; i++) got[i] = tbl_new_weights[i];
               check("wr_addr", RW'(tbl_write_addr), RW'(e.addr));
               check("wr_row", got, e.row);
               check("wr_latency", RW'(cyc), RW'(e.cyc));
            end
         end
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [WW-1:0] v);
      @(negedge clk);
      load_en = 1'b1; load_addr = a; load_val = v;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Issues one update; when a write is expected it lands 7 cycles after the accept edge.
   task automatic send(input logic [AW-1:0] a, input logic [HL-1:0] h, input logic t,
                       input logic signed [SW-1:0] s, input logic expect_wr,
                       input row_t exp_row, input logic hold);
      int   n = 0;
      exp_t e;
      @(negedge clk);
      while (upd_ready !== 1'b1 && n < 50) begin
         upd_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      if (upd_ready !== 1'b1) check("ready_timeout", 0, 1);
      upd_valid = 1'b1; upd_addr = a; upd_history = h; upd_taken = t; upd_sum = s;
      if (expect_wr) begin
         e.addr = a; e.row = exp_row; e.cyc = 32'(cyc + 7);
         sb.push_back(e);
      end
      @(posedge clk);
      if (!hold) #1 upd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", RW'(sb.size()), 0);
      @(negedge clk);
   endtask

   initial begin
      row_t r;
      int   busy;
      rst = 1'b0; upd_valid = 1'b0; upd_addr = '0; upd_history = '0;
      upd_taken = 1'b0; upd_sum = '0; load_en = 1'b0; load_addr = '0; load_val = '0;
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      check("rst_ready", RW'(upd_ready), 1);
      check("rst_write_en", RW'(tbl_write_en), 0);
      check("rst_trained", RW'(trained_cnt), 0);
      check("rst_skipped", RW'(skipped_cnt), 0);
      check("rst_addrs", RW'({tbl_read_addr, tbl_write_addr}), 0);
      for (int i = 0; i <= HL; i++) r[i] = tbl_new_weights[i];
      check("rst_new_weights", r, 0);
      rst = 1'b1;

      // Confident correct prediction: skipped, ready never drops.
      send(7'd3, '0, 1'b1, 15'sd100, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("skip_cnt_1", RW'(skipped_cnt), 1);
      check("skip_ready", RW'(upd_ready), 1);

      // Mispredict on a zero row, all history taken: every weight becomes +1.
      preload(7'd5, 8'h00);
      send(7'd5, '1, 1'b1, -15'sd5, 1'b1, fill(8'h01), 1'b0);
      busy = 0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (upd_ready === 1'b0) busy++;
      end
      check("ready_low_cycles", RW'(busy), 7);
      @(negedge clk);
      check("ready_back_c8", RW'(upd_ready), 1);
      check("trained_cnt_1", RW'(trained_cnt), 1);

      // Not taken, alternating history: odd weights -1, even weights >=2 +1, bias -1.
      preload(7'd6, 8'h00);
      r[0] = 8'hFF;
      for (int j = 1; j <= HL; j++) r[j] = (j % 2 == 1) ? 8'hFF : 8'h01;
      send(7'd6, 32'h5555_5555, 1'b0, -15'sd10, 1'b1, r, 1'b0);
      drain();

      // Saturation at both rails.
      preload(7'd7, 8'h7F);
      send(7'd7, '1, 1'b1, 15'sd0, 1'b1, fill(8'h7F), 1'b0);
      drain();
      preload(7'd8, 8'h80);
      send(7'd8, '1, 1'b0, -15'sd1, 1'b1, fill(8'h80), 1'b0);
      drain();

      // sum=+THETA trains: bias +1, all-not-taken history gives -1 elsewhere.
      preload(7'd9, 8'h00);
      r = fill(8'hFF);
      r[0] = 8'h01;
      send(7'd9, '0, 1'b1, 15'sd75, 1'b1, r, 1'b0);
      drain();

      // Just outside the threshold on both sides: back-to-back skips.
      send(7'd13, '0, 1'b1, 15'sd76, 1'b0, '0, 1'b1);
      send(7'd14, '0, 1'b0, -15'sd76, 1'b0, '0, 1'b0);
      @(negedge clk);
      check("skip_cnt_3", RW'(skipped_cnt), 3);

      // sum=0 with not-taken outcome is a mispredict.
      preload(7'd10, 8'h00);
      r = fill(8'h01);
      r[0] = 8'hFF;
      send(7'd10, '0, 1'b0, 15'sd0, 1'b1, r, 1'b0);
      drain();
      check("trained_cnt_6", RW'(trained_cnt), 6);

      // Reset in UPDATE cycle 4 abandons the write.
      preload(7'd11, 8'h00);
      send(7'd11, '0, 1'b0, 15'sd0, 1'b0, '0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_write_en", RW'(tbl_write_en), 0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", RW'(upd_ready), 1);
      check("abort_counters", RW'({trained_cnt, skipped_cnt}), 0);
      repeat (10) @(negedge clk);

      preload(7'd12, 8'h00);
      send(7'd12, '1, 1'b1, -15'sd5, 1'b1, fill(8'h01), 1'b0);
      drain();
      check("post_rst_trained", RW'(trained_cnt), 1);
      check("sb_empty", RW'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
- Downstream training stage of the perceptron branch predictor, driven by branch resolution.
- Accepts one resolved branch per handshake: table index, global history at prediction time, actual outcome and the predicted dot-product sum.
- Applies the perceptron training rule (train on mispredict or low confidence), reads the weight row from the perceptron weight table, and updates it with saturating ±1 steps over several lane passes.
- Writes the updated row back through the table's single write port.

Parameters:
- NUM_PERCEPTRONS, 128, rows in weight table
- HISTORY_LENGTH, 32, global history bits; row holds HISTORY_LENGTH+1 weights, index 0 = bias
- WEIGHT_WIDTH, 8, signed weight width
- ADDR_WIDTH, $clog2(NUM_PERCEPTRONS), row index width
- SUM_WIDTH, WEIGHT_WIDTH+$clog2(HISTORY_LENGTH+1)+1, signed prediction-sum width
- THETA, 75, training threshold (floor(1.93*H+14))
- LANES, 8, weights updated per cycle

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- upd_valid  in  1  resolved-branch update request
- upd_ready  out  1  trainer can accept an update
- upd_addr  in  ADDR_WIDTH  perceptron row
- upd_history  in  HISTORY_LENGTH  history; bit i-1 feeds weight i, 1 = taken
- upd_taken  in  1  actual outcome
- upd_sum  in  SUM_WIDTH signed  sum computed at prediction
- tbl_read_addr  out  ADDR_WIDTH  row address to table (combinational table read)
- tbl_weights  in  signed WEIGHT_WIDTH x [HISTORY_LENGTH:0]  row read from table
- tbl_write_en  out  1  one-cycle write strobe
- tbl_write_addr  out  ADDR_WIDTH  write row
- tbl_new_weights  out  signed WEIGHT_WIDTH x [HISTORY_LENGTH:0]  updated row
- trained_cnt  out  16  rows written since reset
- skipped_cnt  out  16  updates not requiring training

Behaviour:
- Reset (rst=0, async):
  - State IDLE.
  - upd_ready=1, tbl_write_en=0.
  - Captured addr/history/taken/sum, working row and lane counter cleared.
  - tbl_read_addr=0, tbl_write_addr=0, tbl_new_weights all 0.
  - Counters 0.
  - Reset during any state abandons the update with no write, including assertion in the WRITE cycle.
- FSM IDLE -> FETCH -> UPDATE -> WRITE -> IDLE.
  - upd_ready=1 only in IDLE.
- IDLE:
  - Accept when upd_valid&&upd_ready; capture all upd_* fields.
  - predicted_taken = (upd_sum >= 0).
  - train = (predicted_taken != upd_taken) || (upd_sum <= THETA && upd_sum >= -THETA).
  - Compare signed; no abs(), so the most negative sum does not overflow.
  - !train: skipped_cnt++, remain IDLE; ready stays 1, so back-to-back skips are accepted every cycle.
  - train: go to FETCH.
- tbl_read_addr = captured addr register at all times.
- FETCH: latch tbl_weights into the working row; lane counter=0; go to UPDATE.
- UPDATE:
  - Each cycle, weights j = lane..lane+LANES-1 with j <= HISTORY_LENGTH are updated.
  - t = +1 if taken, else -1.
  - x0 = +1; xj = +1 if history[j-1], else -1.
  - w_j <= sat(w_j + t*xj), clamped to [-2^(W-1), 2^(W-1)-1]. Compute at WEIGHT_WIDTH+1 bits, then clamp.
  - Lanes beyond HISTORY_LENGTH are ignored.
  - Pass count P = ceil((HISTORY_LENGTH+1)/LANES) = 5 by default; go to WRITE after pass P-1.
- WRITE:
  - tbl_write_en=1 for exactly one cycle.
  - tbl_write_addr = captured addr; tbl_new_weights = working row.
  - trained_cnt++; go to IDLE.
- Latency: accept edge -> tbl_write_en high in cycle 2+P after it (7 by default). upd_ready low for cycles 1..2+P, high again in cycle 3+P.
- Write-after-write to the same row is safe: the next FETCH occurs at least one cycle after the write edge and sees the new row.
- tbl_write_en=0 outside WRITE. tbl_write_addr and tbl_new_weights hold their last values.
- Counters saturate at 16'hFFFF.

Test Plan:
- sum=100, taken=1 -> no training: skipped_cnt=1, tbl_write_en never asserts, upd_ready stays 1.
- Row 5 all zeros, sum=-5, taken=1, history=32'hFFFFFFFF -> tbl_write_en in cycle 7 after accept, tbl_write_addr=5, all 33 weights=+1, trained_cnt=1.
- Zero row, sum=-10, taken=0, history=32'h55555555 -> w0=-1; w_j=-1 for odd j (history bit set), +1 for even j>=2.
- Saturation:
  - Row all +127, taken=1, history all ones, sum=0 -> row stays +127.
  - Row all -128, taken=0, history all ones, sum=-1 -> row stays -128.
- Threshold boundaries:
  - sum=75, taken=1 -> trains.
  - sum=76, taken=1 -> skipped.
  - sum=-76, taken=0 -> skipped.
  - sum=0, taken=0 -> trains (mispredict).
- rst low during UPDATE (cycle 4) -> no tbl_write_en; after release upd_ready=1, counters 0. A new update then completes normally with write in cycle 7.
